// File: rtl/nclus_tx.sv
// nclus_tx: tags pre-lv1 triggers with event IDs and pairs them with cluster counts.
// Optional head-of-queue timeout is enabled by defining NCLUS_TX_TIMEOUT_EN.
module nclus_tx #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_live,
  input  logic        in_plv1,
  input  logic        in_clus_valid,
  input  logic [7:0]  in_clus_cnt,
  output logic        out_clus_ready,
  output logic [15:0] out_nclus,
  output logic        fifo_ovf,
  output logic [15:0] timeout_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);
  localparam bit LP_OK = (DEPTH >= 2) && (DEPTH <= 64) &&
                         ((DEPTH & (DEPTH - 1)) == 0) &&
                         (TIMEOUT >= 1) && (TIMEOUT <= 65535);

  if (!LP_OK) begin : g_bad_param
    $error("nclus_tx: DEPTH or TIMEOUT out of range");
  end

  logic [9:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic [9:0]    r_id;
  logic          r_plv1_d;
  logic          r_live_d;
  logic          r_ovf;
  logic [15:0]   r_nclus;

  logic          w_edge;
  logic          w_empty;
  logic          w_full;
  logic          w_ready;
  logic          w_accept;
  logic          w_acc_pop;
  logic          w_discard;
  logic          w_tmo;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_skip_nz;
  logic          w_live_rise;
  logic          w_sat;
  logic [3:0]    w_n4;
  logic [9:0]    w_head;
  logic [15:0]   w_word;

  assign w_edge      = in_plv1 & ~r_plv1_d;
  assign w_empty     = (r_cnt == '0);
  assign w_full      = (r_cnt == LP_FULL);
  assign w_ready     = in_live & (~w_empty | w_skip_nz);
  assign w_accept    = in_clus_valid & w_ready;
  assign w_discard   = w_accept & w_skip_nz;
  assign w_acc_pop   = w_accept & ~w_skip_nz;
  assign w_pop       = w_acc_pop | w_tmo;
  assign w_push      = in_live & w_edge & (~w_full | w_pop);
  assign w_drop      = in_live & w_edge & w_full & ~w_pop;
  assign w_live_rise = in_live & ~r_live_d;
  assign w_head      = r_mem[r_rp];
  assign w_sat       = |in_clus_cnt[7:4];
  assign w_n4        = w_sat ? 4'hF : in_clus_cnt[3:0];

  assign out_clus_ready = w_ready;
  assign out_nclus      = r_nclus;
  assign fifo_ovf       = r_ovf;

`ifdef NCLUS_TX_TIMEOUT_EN
  logic [15:0] r_age;
  logic [6:0]  r_skip;
  logic [15:0] r_tmo_cnt;

  assign w_skip_nz   = |r_skip;
  assign w_tmo       = in_live & ~w_empty & ~w_accept &
                       (r_age == 16'(TIMEOUT));
  assign timeout_cnt = r_tmo_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_age <= '0;
    end else if (!in_live || w_pop || w_empty) begin
      r_age <= '0;
    end else if (!w_accept) begin
      r_age <= r_age + 16'd1;
    end
  end

  // skip count tracks late results still owed for timed-out events
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skip <= '0;
    end else if (!in_live) begin
      r_skip <= '0;
    end else if (w_tmo) begin
      if (r_skip != 7'd127) r_skip <= r_skip + 7'd1;
    end else if (w_discard) begin
      r_skip <= r_skip - 7'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
    end else if (w_live_rise) begin
      r_tmo_cnt <= '0;
    end else if (w_tmo && r_tmo_cnt != 16'hFFFF) begin
      r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end
  end
`else
  assign w_skip_nz   = 1'b0;
  assign w_tmo       = 1'b0;
  assign timeout_cnt = 16'h0000;
`endif

  always_comb begin
    w_word = 16'h0000;
    unique case (1'b1)
      w_acc_pop: w_word = {1'b1, w_sat, w_n4, w_head};
      w_tmo:     w_word = {2'b00, 4'hF, w_head};
      default:   w_word = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_plv1_d <= 1'b0;
      r_live_d <= 1'b0;
      r_id     <= '0;
      r_nclus  <= '0;
    end else begin
      r_live_d <= in_live;
      r_nclus  <= w_word;
      if (!in_live) begin
        r_plv1_d <= 1'b0;
        r_id     <= '0;
      end else begin
        r_plv1_d <= in_plv1;
        if (w_edge) r_id <= r_id + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (!in_live) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wp] <= r_id;
    end
  end

  // dropped IDs still consume a number so the lv1a side sees the gap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_live_rise) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nclus_tx.sv
// Directed self-checking bench for nclus_tx.
// Timeout checks follow NCLUS_TX_TIMEOUT_EN as the design does.
module tb_nclus_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_live = 1'b0;
  logic        in_plv1 = 1'b0;
  logic        in_clus_valid = 1'b0;
  logic [7:0]  in_clus_cnt = 8'd0;
  logic        out_clus_ready;
  logic [15:0] out_nclus;
  logic        fifo_ovf;
  logic [15:0] timeout_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  nclus_tx #(.DEPTH(16), .TIMEOUT(255)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_live        (in_live),
    .in_plv1        (in_plv1),
    .in_clus_valid  (in_clus_valid),
    .in_clus_cnt    (in_clus_cnt),
    .out_clus_ready (out_clus_ready),
    .out_nclus      (out_nclus),
    .fifo_ovf       (fifo_ovf),
    .timeout_cnt    (timeout_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    in_plv1 = 1'b1;
    repeat (3) tick();
    in_plv1 = 1'b0;
    tick();
  endtask

  task automatic relive();
    in_live = 1'b0;
    tick();
    in_live = 1'b1;
    tick();
  endtask

  logic [15:0] exp_w;

  initial begin
    #3;
    chk("rst_nclus", out_nclus, 16'h0000);
    chk("rst_ready", {15'b0, out_clus_ready}, 16'h0000);
    chk("rst_ovf", {15'b0, fifo_ovf}, 16'h0000);
    chk("rst_tmo", timeout_cnt, 16'h0000);
    repeat (2) tick();
    rst_n   = 1'b1;
    in_live = 1'b1;
    tick();
    chk("idle_ready", {15'b0, out_clus_ready}, 16'h0000);

    // three events, results 3, 7, 20
    repeat (3) pulse();
    chk("t030_ready", {15'b0, out_clus_ready}, 16'h0001);
    in_clus_valid = 1'b1;
    in_clus_cnt = 8'd3;
    tick();
    chk("t030_w0", out_nclus, 16'h8C00);
    in_clus_cnt = 8'd7;
    tick();
    chk("t030_w1", out_nclus, 16'h9C01);
    in_clus_cnt = 8'd20;
    tick();
    chk("t030_w2", out_nclus, 16'hFC02);
    chk("t030_empty_ready", {15'b0, out_clus_ready}, 16'h0000);
    in_clus_valid = 1'b0;
    tick();
    chk("t030_idle", out_nclus, 16'h0000);

    // overflow: 17 pulses into a 16-deep FIFO
    relive();
    repeat (16) pulse();
    chk("t031_ovf_pre", {15'b0, fifo_ovf}, 16'h0000);
    pulse();
    chk("t031_ovf", {15'b0, fifo_ovf}, 16'h0001);
    in_clus_valid = 1'b1;
    in_clus_cnt = 8'd0;
    tick();
    chk("t031_id0", out_nclus, 16'h8000);
    in_clus_valid = 1'b0;
    pulse();
    chk("t031_ovf_held", {15'b0, fifo_ovf}, 16'h0001);
    in_clus_valid = 1'b1;
    for (int i = 1; i < 16; i++) begin
      tick();
      exp_w = 16'h8000 | 16'(i);
      chk("t031_drain", out_nclus, exp_w);
    end
    tick();
    chk("t031_id17", out_nclus, 16'h8011);
    chk("t031_ready", {15'b0, out_clus_ready}, 16'h0000);
    in_clus_valid = 1'b0;
    tick();
    chk("t031_idle", out_nclus, 16'h0000);

    // live drop with four events pending
    repeat (4) pulse();
    chk("t034_ready_on", {15'b0, out_clus_ready}, 16'h0001);
    in_live = 1'b0;
    tick();
    chk("t034_off_nclus", out_nclus, 16'h0000);
    chk("t034_off_ready", {15'b0, out_clus_ready}, 16'h0000);
    tick();
    chk("t034_ovf_hold", {15'b0, fifo_ovf}, 16'h0001);
    in_live = 1'b1;
    tick();
    chk("t034_ovf_clr", {15'b0, fifo_ovf}, 16'h0000);
    chk("t034_tmo_clr", timeout_cnt, 16'h0000);
    chk("t034_ready", {15'b0, out_clus_ready}, 16'h0000);
    chk("t034_nclus", out_nclus, 16'h0000);
    pulse();
    in_clus_valid = 1'b1;
    in_clus_cnt = 8'd5;
    tick();
    chk("t034_id0", out_nclus, 16'h9400);
    in_clus_valid = 1'b0;
    tick();

    // head waits 256 cycles with no result
    relive();
    pulse();
    for (int k = 4; k < 256; k++) begin
      tick();
      chk("t032_wait", out_nclus, 16'h0000);
    end
    tick();
`ifdef NCLUS_TX_TIMEOUT_EN
    chk("t032_tmo_word", out_nclus, 16'h3C00);
    chk("t032_tmo_cnt", timeout_cnt, 16'h0001);
    chk("t032_skip_ready", {15'b0, out_clus_ready}, 16'h0001);
    in_clus_valid = 1'b1;
    in_clus_cnt = 8'd5;
    tick();
    chk("t032_discard", out_nclus, 16'h0000);
    chk("t032_ready_off", {15'b0, out_clus_ready}, 16'h0000);
`else
    chk("t032_no_tmo", out_nclus, 16'h0000);
    chk("t032_tmo_cnt", timeout_cnt, 16'h0000);
    chk("t032_ready", {15'b0, out_clus_ready}, 16'h0001);
    in_clus_valid = 1'b1;
    in_clus_cnt = 8'd5;
    tick();
    chk("t032_late_id0", out_nclus, 16'h9400);
`endif
    in_clus_valid = 1'b0;
    pulse();
    in_clus_valid = 1'b1;
    in_clus_cnt = 8'd5;
    tick();
    chk("t032_id1", out_nclus, 16'h9401);
    in_clus_valid = 1'b0;
    tick();

    // 1030 events, ID wraps after 1023
    relive();
    for (int i = 0; i < 1030; i++) begin
      pulse();
      in_clus_valid = 1'b1;
      in_clus_cnt = 8'(i % 16);
      tick();
      exp_w = 16'h8000 | 16'((i % 16) << 10) | 16'(i % 1024);
      chk("t033_wrap", out_nclus, exp_w);
      in_clus_valid = 1'b0;
    end

    // reset asserted in the middle of an accept cycle
    relive();
    pulse();
    pulse();
    in_clus_valid = 1'b1;
    in_clus_cnt = 8'd2;
    tick();
    chk("t035_pre", out_nclus, 16'h8800);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t035_async_nclus", out_nclus, 16'h0000);
    chk("t035_async_ready", {15'b0, out_clus_ready}, 16'h0000);
    tick();
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      chk("t035_post_nclus", out_nclus, 16'h0000);
      chk("t035_post_ready", {15'b0, out_clus_ready}, 16'h0000);
    end
    in_clus_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
